id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

Parametrised ID/EX pipeline register with a valid/ready handshake, a two-entry skid buffer and synchronous flush. It sits between the decode stage and the execute stage. It carries two operand values, an immediate, the destination register and a control bundle. It lets execute stall decode without a combinational ready path and lets the hazard/branch logic squash in-flight instructions.

## Interface
Parameters:
- DATA_W, 32, width of operand and immediate buses
- REG_ADDR_W, 5, width of destination register index
- CTRL_W, 8, width of opaque control bundle (ALU op, reg-write, mem flags)

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset (asserted at 0); one clock, reset is asynchronous and active-low
- in_valid  input  1  decode offers a beat
- in_ready  output  1  block can accept a beat; registered
- data_1_in  input  DATA_W  operand 1
- data_2_in  input  DATA_W  operand 2
- imm_in  input  DATA_W  immediate
- rd_in  input  REG_ADDR_W  destination register
- ctrl_in  input  CTRL_W  control bundle
- flush  input  1  synchronous squash of all held beats
- out_valid  output  1  execute-side beat valid
- out_ready  input  1  execute accepts beat
- data_1_out, data_2_out, imm_out  output  DATA_W  registered payload
- rd_out  output  REG_ADDR_W  registered payload
- ctrl_out  output  CTRL_W  registered payload
- stall_cnt  output  16  present only with ID_EX_STALL_CNT_EN

## Operation
- Accept event: in_valid & in_ready. Issue event: out_valid & out_ready.
- Storage: main register (drives outputs) and skid register. Occupancy FSM: EMPTY, ONE (main full), TWO (main + skid full).
- in_ready = (next state != TWO), registered; out_valid = (state != EMPTY).
- EMPTY: accept -> main <= input, ONE.
- ONE: accept & !issue -> skid <= input, TWO. Accept & issue -> main <= input, stay ONE. Issue only -> EMPTY. Neither -> hold.
- TWO: issue -> main <= skid, ONE. Otherwise hold. No accept is possible because in_ready = 0.
- flush has top priority. Next state is EMPTY. Main and skid payloads are cleared to 0. in_ready = 1 next cycle. A beat offered in the flush cycle is dropped, even if in_ready was 1. An issue in the same cycle still counts as completed for execute.
- On drain to EMPTY without flush, payload outputs hold their last value. Only out_valid drops.
- Ordering: beats issue strictly in acceptance order; no beat is duplicated or lost except by flush.

## Timing
- Reset (rst = 0, asynchronous): state EMPTY, out_valid 0, in_ready 1, all payload outputs 0, stall_cnt 0.
- Leaving reset takes effect on the first posedge with rst = 1.
- Latency: a beat accepted at edge N appears on the outputs with out_valid = 1 after edge N.
- Throughput: one beat per cycle when out_ready is held at 1.
- Backpressure: the first cycle out_ready = 0 with a beat in flight is absorbed by skid. in_ready falls after the next edge.
- Reset asserted mid-operation: all beats are discarded immediately and outputs return to reset values without waiting for clk.

## Configuration
- ID_EX_STALL_CNT_EN defined:
  - stall_cnt port exists.
  - It increments by 1 on each posedge with out_valid = 1 and out_ready = 0.
  - It saturates at 16'hFFFF.
  - It is cleared only by rst; flush does not clear it.
- Macro undefined: stall_cnt port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then in_valid = 1 with data_1_in = 32'h1, data_2_in = 32'h2, rd_in = 5'd7, out_ready = 1 -> out_valid = 1 one cycle later with the same values; in_ready stays 1.
- Stream beats 1..8 back-to-back with out_ready = 1 -> outputs 1..8 on consecutive cycles with no bubbles.
- Send beats A, B, C with out_ready = 0 from the cycle after A is accepted:
  - A and B are held; in_ready = 0 and C waits.
  - Raise out_ready -> order A, B, C with no loss.
- In state TWO, assert flush for one cycle while in_valid = 1 -> next cycle out_valid = 0, payload 0, in_ready = 1, and the offered beat never appears.
- Hold out_valid = 1 and out_ready = 0 for 5 cycles -> stall_cnt = 5 (ID_EX_STALL_CNT_EN). Then flush -> stall_cnt is still 5.
- Assert rst = 0 between clock edges while in TWO -> out_valid = 0, in_ready = 1 and outputs 0 before the next posedge.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: valid/ready handshake, two-entry skid buffer, synchronous flush.
// Optional stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     data_1_in,
  input  logic [DATA_W-1:0]     data_2_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     data_1_out,
  output logic [DATA_W-1:0]     data_2_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [CTRL_W-1:0]     ctrl_out
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int unsigned STALL_W = 16;

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     data_2;
    logic [DATA_W-1:0]     data_1;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  beat_t  in_beat;
  logic   in_ready_d;
  logic   out_valid_d;
  logic   accept;
  logic   issue;

  assign in_beat = '{ctrl: ctrl_in, rd: rd_in, imm: imm_in, data_2: data_2_in, data_1: data_1_in};
  assign accept  = in_valid & in_ready;
  assign issue   = out_valid & out_ready;

  // State register and payload storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Occupancy next-state and payload steering; flush overrides everything
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_beat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && !issue) begin
          skid_d  = in_beat;
          state_d = TWO;
        end else if (accept && issue) begin
          main_d  = in_beat;
        end else if (issue) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (issue) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  assign data_1_out = main_q.data_1;
  assign data_2_out = main_q.data_2;
  assign imm_out    = main_q.imm;
  assign rd_out     = main_q.rd;
  assign ctrl_out   = main_q.ctrl;

`ifdef ID_EX_STALL_CNT_EN
  // Saturating count of cycles where execute holds off a valid beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  // Stall counter not present in this build.
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_1_in = '0;
  logic [31:0] data_2_in = '0;
  logic [31:0] imm_in = '0;
  logic [4:0]  rd_in = '0;
  logic [7:0]  ctrl_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] data_1_out;
  logic [31:0] data_2_out;
  logic [31:0] imm_out;
  logic [4:0]  rd_out;
  logic [7:0]  ctrl_out;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_1_in(data_1_in), .data_2_in(data_2_in), .imm_in(imm_in),
    .rd_in(rd_in), .ctrl_in(ctrl_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_1_out(data_1_out), .data_2_out(data_2_out), .imm_out(imm_out),
    .rd_out(rd_out), .ctrl_out(ctrl_out)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a beat whose fields are all derived from one tag value
  task automatic drive(input logic [31:0] v);
    in_valid  = 1'b1;
    data_1_in = v;
    data_2_in = v + 32'h1000;
    imm_in    = v + 32'h2000;
    rd_in     = v[4:0];
    ctrl_in   = v[7:0];
  endtask

  task automatic check_stall(input string tag, input int exp);
`ifdef ID_EX_STALL_CNT_EN
    check(tag, 64'(stall_cnt), 64'(exp));
`else
    if (exp < 0) $display("unexpected negative %s", tag);
`endif
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_data_1", 64'(data_1_out), 64'd0);
    check("rst_ctrl", 64'(ctrl_out), 64'd0);
    check_stall("rst_stall", 0);
    #5 rst = 1'b1;

    // Single beat
    in_valid = 1'b1; data_1_in = 32'h1; data_2_in = 32'h2; imm_in = 32'h3;
    rd_in = 5'd7; ctrl_in = 8'h5A; out_ready = 1'b1;
    step();
    check("one_valid", 64'(out_valid), 64'd1);
    check("one_data_1", 64'(data_1_out), 64'h1);
    check("one_data_2", 64'(data_2_out), 64'h2);
    check("one_imm", 64'(imm_out), 64'h3);
    check("one_rd", 64'(rd_out), 64'd7);
    check("one_ctrl", 64'(ctrl_out), 64'h5A);
    check("one_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back stream with no bubbles
    for (int k = 1; k <= 8; k++) begin
      drive(32'h100 + 32'(k));
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data_1", 64'(data_1_out), 64'(32'h100 + 32'(k)));
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    check("stream_data_2", 64'(data_2_out), 64'h1108);
    check("stream_rd", 64'(rd_out), 64'h08);
    in_valid = 1'b0;
    step();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_hold", 64'(data_1_out), 64'h108);
    check("drain_imm_hold", 64'(imm_out), 64'h2108);

    // Backpressure: A, B held, C waits, then ordered release
    drive(32'hA);
    step();
    check("bp_a", 64'(data_1_out), 64'hA);
    out_ready = 1'b0;
    drive(32'hB);
    step();
    check("bp_hold_a", 64'(data_1_out), 64'hA);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    drive(32'hC);
    step();
    check("bp_still_a", 64'(data_1_out), 64'hA);
    check("bp_still_low", 64'(in_ready), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_b", 64'(data_1_out), 64'hB);
    check("bp_b_imm", 64'(imm_out), 64'h200B);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    check("bp_c", 64'(data_1_out), 64'hC);
    in_valid = 1'b0;
    step();
    check("bp_empty", 64'(out_valid), 64'd0);
    check_stall("bp_stall", 2);

    // Flush while holding two beats, with a beat offered in the same cycle
    drive(32'h21);
    step();
    out_ready = 1'b0;
    drive(32'h22);
    step();
    check("fl_two", 64'(in_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(32'h99);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_data_1", 64'(data_1_out), 64'd0);
    check("fl_ctrl", 64'(ctrl_out), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("fl_no_ghost", 64'(out_valid), 64'd0);
    end
    check_stall("fl_stall", 3);

    // Five stall cycles, then flush must not clear the counter
    drive(32'h31);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("st_hold", 64'(data_1_out), 64'h31);
    check_stall("st_five", 8);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    check_stall("st_after_flush", 8);
    check("st_flushed", 64'(out_valid), 64'd0);

    // Asynchronous reset in state TWO, between clock edges
    drive(32'h41);
    step();
    out_ready = 1'b0;
    drive(32'h42);
    step();
    in_valid = 1'b0;
    check("ar_two", 64'(in_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    check("ar_data_1", 64'(data_1_out), 64'd0);
    check("ar_rd", 64'(rd_out), 64'd0);
    check_stall("ar_stall", 0);
    #3 rst = 1'b1;
    step();
    check("ar_stays_empty", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
